// File: rtl/ps2_transmitter_if.sv
// Host-side handshake and status bundle for the PS/2 host-to-device transmitter.
// master: the logic that issues command bytes; slave: the transmitter itself.
interface ps2_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  ack_err,
        input  timeout_err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output ack_err,
        output timeout_err
    );
endinterface

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard over
// the open-drain clock/data pair and reports done, missing ack or timeout.
// The *_oe outputs are active-high pull-low enables for the top-level tristates.
// Optional macro PS2_TX_RETRY_EN: retry a failed byte once before reporting.
module ps2_transmitter #(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned INHIBIT_US     = 120,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    ps2_transmitter_if.slave tx,
    input  logic             ps2_clk_in,
    input  logic             ps2_data_in,
    output logic             ps2_clk_oe,
    output logic             ps2_data_oe
);

    localparam int unsigned INHIBIT_CYCLES = CLK_FREQ / 1_000_000 * INHIBIT_US;
    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_XFER,
        S_ACK,
        S_WAIT_IDLE,
        S_ERR
    } state_t;

    // Synchroniser and clock filter
    logic             clk_meta, clk_sync, data_meta, data_sync;
    logic             clk_filt, clk_filt_d;
    logic [FLT_W-1:0] flt_cnt;
    logic             fall;

    // FSM state and datapath
    state_t           state, state_nxt;
    logic [INH_W-1:0] inh_cnt, inh_cnt_nxt;
    logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
    logic [3:0]       bit_idx, bit_idx_nxt, bit_k;
    logic [8:0]       frame, frame_nxt;          // {parity, data}
    logic             data_oe_q, data_oe_nxt;
    logic             err_to_q, err_to_nxt;      // 1 = timeout, 0 = missing ack
    logic             done_q, done_nxt;
    logic             ack_err_q, ack_err_nxt;
    logic             timeout_err_q, timeout_err_nxt;
`ifdef PS2_TX_RETRY_EN
    logic             retried, retried_nxt;
`endif

    // Two-stage synchronisers; idle PS/2 lines float high.
    // NOTE: flops use non-blocking assignments so every stage samples the
    // previous stage's old value, which is what makes this a real 2-FF chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    // Clock filter: adopt a new level only after FILTER_LEN agreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            flt_cnt    <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_sync == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fall  = clk_filt_d & ~clk_filt;
    assign bit_k = bit_idx + 4'd1;

    // FSM register and datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            inh_cnt       <= '0;
            to_cnt        <= '0;
            bit_idx       <= '0;
            frame         <= '0;
            data_oe_q     <= 1'b0;
            err_to_q      <= 1'b0;
            done_q        <= 1'b0;
            ack_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retried       <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            inh_cnt       <= inh_cnt_nxt;
            to_cnt        <= to_cnt_nxt;
            bit_idx       <= bit_idx_nxt;
            frame         <= frame_nxt;
            data_oe_q     <= data_oe_nxt;
            err_to_q      <= err_to_nxt;
            done_q        <= done_nxt;
            ack_err_q     <= ack_err_nxt;
            timeout_err_q <= timeout_err_nxt;
`ifdef PS2_TX_RETRY_EN
            retried       <= retried_nxt;
`endif
        end
    end

    // Next-state logic: sequencing, bit shifting on falls, timeout and errors.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt       = state;
        inh_cnt_nxt     = inh_cnt;
        to_cnt_nxt      = to_cnt;
        bit_idx_nxt     = bit_idx;
        frame_nxt       = frame;
        data_oe_nxt     = data_oe_q;
        err_to_nxt      = err_to_q;
        done_nxt        = 1'b0;
        ack_err_nxt     = 1'b0;
        timeout_err_nxt = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retried_nxt     = retried;
`endif
        case (state)
            S_IDLE: begin
                data_oe_nxt = 1'b0;
                if (tx.tx_valid && tx.tx_ready) begin
                    frame_nxt   = {~^tx.tx_data, tx.tx_data};
                    inh_cnt_nxt = '0;
                    state_nxt   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retried_nxt = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    data_oe_nxt = 1'b1;          // start bit, held through RTS
                    state_nxt   = S_RTS;
                end else begin
                    inh_cnt_nxt = inh_cnt + 1'b1;
                end
            end
            S_RTS: begin
                bit_idx_nxt = '0;
                to_cnt_nxt  = '0;
                state_nxt   = S_XFER;
            end
            S_XFER, S_ACK: begin
                // A fall in the same cycle as the timeout still counts.
                if (fall) begin
                    to_cnt_nxt  = '0;
                    bit_idx_nxt = bit_k;
                    if (state == S_XFER) begin
                        if (bit_k == 4'd10) begin
                            data_oe_nxt = 1'b0;  // stop bit
                            state_nxt   = S_ACK;
                        end else begin
                            data_oe_nxt = ~frame[bit_idx];
                        end
                    end else if (!data_sync) begin
                        state_nxt = S_WAIT_IDLE;
                    end else begin
                        err_to_nxt = 1'b0;
                        state_nxt  = S_ERR;
                    end
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_to_nxt  = 1'b1;
                    data_oe_nxt = 1'b0;
                    state_nxt   = S_ERR;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_filt && data_sync) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                data_oe_nxt = 1'b0;
`ifdef PS2_TX_RETRY_EN
                if (!retried) begin
                    retried_nxt = 1'b1;
                    inh_cnt_nxt = '0;
                    state_nxt   = S_INHIBIT;
                end else begin
                    ack_err_nxt     = ~err_to_q;
                    timeout_err_nxt = err_to_q;
                    state_nxt       = S_IDLE;
                end
`else
                ack_err_nxt     = ~err_to_q;
                timeout_err_nxt = err_to_q;
                state_nxt       = S_IDLE;
`endif
            end
            default: begin
                data_oe_nxt = 1'b0;
                state_nxt   = S_IDLE;
            end
        endcase
    end

    assign tx.tx_ready    = rst_n && (state == S_IDLE);
    assign tx.busy        = (state != S_IDLE);
    assign tx.done        = done_q;
    assign tx.ack_err     = ack_err_q;
    assign tx.timeout_err = timeout_err_q;
    assign ps2_clk_oe     = (state == S_INHIBIT) || (state == S_RTS);
    assign ps2_data_oe    = data_oe_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with a behavioural PS/2 keyboard on the
// wired-AND lines. Small CLK_FREQ/TIMEOUT keep the run short.
`timescale 1ns/1ps
module tb_ps2_transmitter;

    localparam int unsigned CLK_FREQ   = 1_000_000;
    localparam int unsigned INHIBIT_US = 120;
    localparam int unsigned INH_CYC    = 120;     // 1 MHz * 120 us
    localparam int unsigned TIMEOUT    = 2000;
    localparam int unsigned FLT        = 8;
    localparam int          HALF       = 25;      // device half clock period

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;

    ps2_transmitter_if bus();

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_transmitter #(
        .CLK_FREQ      (CLK_FREQ),
        .INHIBIT_US    (INHIBIT_US),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FILTER_LEN    (FLT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx         (bus),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_done = 0, n_ack = 0, n_to = 0, to_cyc = 0;
    int total = 0, bad = 0;
    int last_fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters for the three completion outputs.
    always @(negedge clk) begin
        if (bus.done === 1'b1) n_done <= n_done + 1;
        if (bus.ack_err === 1'b1) n_ack <= n_ack + 1;
        if (bus.timeout_err === 1'b1) begin
            n_to   <= n_to + 1;
            to_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int budget;
        budget = 0;
        while (bus.tx_ready !== 1'b1 && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        check(tag, budget < 5000, 1);
        repeat (2) @(negedge clk);
    endtask

    // Keyboard model: counts the inhibit time, then clocks n_falls bits,
    // sampling data just before each rising edge into rx[k-1].
    task automatic dev_run(input int n_falls, input bit do_ack, input int glitch_after,
                           output logic [10:0] rx, output int inh);
        int budget;
        rx = '1;
        inh = 0;
        budget = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && budget < 5000) begin
            if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) inh++;
            @(negedge clk);
            budget++;
        end
        check("rts_seen", budget < 5000, 1);
        if (budget >= 5000) return;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= n_falls; k++) begin
            if (k == 11 && do_ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            if (k == n_falls) last_fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            rx[k-1] = ps2_data_in;
            dev_clk_low = 1'b0;
            if (k == glitch_after) begin
                repeat (14) @(negedge clk);
                glitch = 1'b1;
                repeat (3) @(negedge clk);
                glitch = 1'b0;
                repeat (HALF - 17) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (k == 11) dev_data_low = 1'b0;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] rx;
        int inh, d0, a0, t0, lat;

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.tx_ready, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_pulses", {bus.done, bus.ack_err, bus.timeout_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", bus.tx_ready, 1);

        // 0xED acknowledged: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(8'hED);
        check("ed_busy", bus.busy, 1);
        check("ed_not_ready", bus.tx_ready, 0);
        dev_run(11, 1'b1, 0, rx, inh);
        check("ed_inhibit", inh, INH_CYC);
        check("ed_data", rx[7:0], 8'hED);
        check("ed_parity", rx[8], 1);
        check("ed_stop", rx[9], 1);
        check("ed_ack_low", rx[10], 0);
        wait_ready("ed_ready");
        check("ed_done", n_done - d0, 1);
        check("ed_no_err", (n_ack - a0) + (n_to - t0), 0);
        check("ed_release", {ps2_clk_oe, ps2_data_oe, bus.busy}, 0);

        // 0xF4: five ones, parity 0
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(8'hF4);
        dev_run(11, 1'b1, 0, rx, inh);
        check("f4_data", rx[7:0], 8'hF4);
        check("f4_parity", rx[8], 0);
        wait_ready("f4_ready");
        check("f4_done", n_done - d0, 1);
        check("f4_no_err", (n_ack - a0) + (n_to - t0), 0);

        // 0x5A without acknowledge
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(8'h5A);
        dev_run(11, 1'b0, 0, rx, inh);
        check("na_data", rx[7:0], 8'h5A);
        check("na_parity", rx[8], 1);
        check("na_no_ack", rx[10], 1);
`ifdef PS2_TX_RETRY_EN
        check("na_retry_busy", bus.busy, 1);
        dev_run(11, 1'b0, 0, rx, inh);
        check("na_retry_data", rx[7:0], 8'h5A);
`endif
        wait_ready("na_ready");
        check("na_ack_err", n_ack - a0, 1);
        check("na_no_done", n_done - d0, 0);
        check("na_no_to", n_to - t0, 0);
        check("na_release", {ps2_clk_oe, ps2_data_oe}, 0);

        // 0x3C: device stops after fall 4
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(8'h3C);
        dev_run(4, 1'b1, 0, rx, inh);
        check("to_first_bits", rx[3:0], 4'hC);
`ifdef PS2_TX_RETRY_EN
        dev_run(11, 1'b1, 0, rx, inh);
        check("to_retry_inhibit", inh, INH_CYC);
        check("to_retry_data", rx[7:0], 8'h3C);
        wait_ready("to_retry_ready");
        check("to_retry_done", n_done - d0, 1);
        check("to_retry_no_err", (n_ack - a0) + (n_to - t0), 0);
`else
        wait_ready("to_ready");
        lat = to_cyc - last_fall_cyc;
        check("to_pulse", n_to - t0, 1);
        check("to_latency", (lat >= int'(TIMEOUT + FLT)) && (lat <= int'(TIMEOUT + FLT + 6)), 1);
        check("to_no_done", (n_done - d0) + (n_ack - a0), 0);
        check("to_release", {ps2_clk_oe, ps2_data_oe}, 0);
`endif

        // 0x0F: reset while bit 4 (a 0) is driven, then 0xFF completes
        send(8'h0F);
        dev_run(5, 1'b1, 0, rx, inh);
        check("rs_pre_data_oe", ps2_data_oe, 1);
        rst_n = 1'b0;
        #1;
        check("rs_clk_oe", ps2_clk_oe, 0);
        check("rs_data_oe", ps2_data_oe, 0);
        check("rs_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rs_ready", bus.tx_ready, 1);
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(8'hFF);
        dev_run(11, 1'b1, 0, rx, inh);
        check("ff_inhibit", inh, INH_CYC);
        check("ff_data", rx[7:0], 8'hFF);
        check("ff_parity", rx[8], 1);
        wait_ready("ff_ready");
        check("ff_done", n_done - d0, 1);
        check("ff_no_err", (n_ack - a0) + (n_to - t0), 0);

        // 0xA5 with a 3-cycle clock glitch and tx_valid pulsed while busy
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(8'hA5);
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.tx_valid = 1'b0;
        dev_run(11, 1'b1, 2, rx, inh);
        check("gl_data", rx[7:0], 8'hA5);
        check("gl_parity", rx[8], 1);
        check("gl_stop", rx[9], 1);
        wait_ready("gl_ready");
        check("gl_done", n_done - d0, 1);
        check("gl_no_err", (n_ack - a0) + (n_to - t0), 0);
        repeat (20) @(negedge clk);
        check("gl_no_extra", {bus.busy, ps2_clk_oe, ps2_data_oe}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
